stage_out_buffer: RTL

- Output stage directly downstream of the two-stage `sub` data pipeline (stage1 -> stage2 -> stage3).
- Captures `stage3_data` words, qualified by a valid strobe, into a small FIFO.
- Presents the words to the consumer through a valid/ready handshake.
- Reports occupancy and a sticky overflow flag, because the upstream pipeline cannot stall.

---
 rtl/stage_out_buffer.sv | 69 ++++++
 1 files changed

// File: rtl/stage_out_buffer.sv
// stage_out_buffer: output FIFO after the stage3 pipeline, valid/ready to consumer, sticky overflow
// Ports: clk, rst (sync, active-high); in_valid/in_data push side, in_ready = !full (advisory);
//        out_valid/out_ready/out_data pop side, out_data is 0 when empty; count = occupancy;
//        overflow sticky on dropped push, cleared by clear_ovf (set wins).
// Macro STAGE_OUT_BUFFER_PARITY_EN: stores even parity with each word and adds out_parity.
module stage_out_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
`ifdef STAGE_OUT_BUFFER_PARITY_EN
  output logic             out_parity,
`endif
  output logic             overflow,
  input  logic             clear_ovf
);
  localparam int AW = $clog2(DEPTH);
`ifdef STAGE_OUT_BUFFER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  logic [SW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full, w_push, w_pop, w_drop;
  logic [SW-1:0] w_wdata, w_head;
  assign w_full = r_count == CW'(DEPTH);
  assign w_push = in_valid && !w_full;
  assign w_drop = in_valid && w_full;
  assign w_pop = out_valid && out_ready;
`ifdef STAGE_OUT_BUFFER_PARITY_EN
  assign w_wdata = {^in_data, in_data};
  assign out_parity = out_valid ? w_head[WIDTH] : 1'b0;
`else
  assign w_wdata = in_data;
`endif
  assign w_head = r_mem[r_rd];
  assign out_valid = r_count != '0;
  assign out_data = out_valid ? w_head[WIDTH-1:0] : '0;
  assign in_ready = !w_full;
  assign count = r_count;
  assign overflow = r_ovf;
  always_ff @(posedge clk)
    if (w_push && !rst) r_mem[r_wr] <= w_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf <= w_drop ? 1'b1 : clear_ovf ? 1'b0 : r_ovf;
    end
  end
endmodule
